// File: rtl/bin2bcd_dd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_dd_ctrl_if
//  Purpose  : Handshake/data bundle for the bin2bcd_dd_ctrl converter.
//  Signals  : start   - conversion request (master -> slave)
//             bin_in  - binary operand, BIN_W bits (master -> slave)
//             busy    - converter occupied (slave -> master)
//             done    - one-cycle completion pulse (slave -> master)
//             bcd_out - result, 4*DIGITS bits, digit 0 = units (slave -> master)
//             ovf     - result needed more than DIGITS digits (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_dd_ctrl_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_dd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_dd_ctrl
//  Purpose  : Multi-cycle binary-to-BCD converter (shift-and-add-3). One digit
//             correction plus one shift per clock, BIN_W clocks per operand,
//             wrapped in a start/busy/done handshake.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - bin2bcd_dd_ctrl_if.slave (start, bin_in, busy, done,
//                    bcd_out, ovf)
//  Config   : BIN2BCD_XS3_OUT_EN - when defined, the registered result is
//             Excess-3 coded (each digit + 3); otherwise plain 8421 BCD.
//  Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_dd_ctrl #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bin2bcd_dd_ctrl_if.slave  bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [BIN_W-1:0]   r_bin_sh;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_int;
  logic [ACC_W-1:0]   r_bcd_out;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic               w_busy;
  logic               w_done;

  logic [ACC_W-1:0]   w_acc_adj;
  logic [ACC_W-1:0]   w_acc_shift;
  logic [BIN_W-1:0]   w_bin_shift;
  logic               w_carry;
  logic               w_ovf_step;
  logic [ACC_W-1:0]   w_result;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        w_busy = 1'b1;
        if (r_cnt == c_CNT_ONE) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here; the next accept can
        // only happen from IDLE.
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Digit correction: any digit >= 5 gets +3 so that the following shift
  // carries correctly into the next decimal digit. The add wraps inside the
  // 4-bit slice; the top slice's overflow is picked up by the shift below.
  // --------------------------------------------------------------------------
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] w_slice;
    assign w_slice                = r_acc[4*d +: 4];
    assign w_acc_adj[4*d +: 4]    = (w_slice >= 4'd5) ? (w_slice + 4'd3) : w_slice;
  end

  // {carry, acc, bin_sh} << 1 : the operand MSB enters the units digit and
  // the bit leaving the top digit marks a value beyond DIGITS digits.
  assign w_carry     = w_acc_adj[ACC_W-1];
  assign w_acc_shift = {w_acc_adj[ACC_W-2:0], r_bin_sh[BIN_W-1]};
  assign w_bin_shift = r_bin_sh << 1;
  assign w_ovf_step  = r_ovf_int | w_carry;

  // --------------------------------------------------------------------------
  // Output encoding applied only at the moment the result is registered.
  // --------------------------------------------------------------------------
`ifdef BIN2BCD_XS3_OUT_EN
  for (genvar d = 0; d < DIGITS; d++) begin : g_xs3
    assign w_result[4*d +: 4] = w_acc_shift[4*d +: 4] + 4'd3;
  end
`else
  assign w_result = w_acc_shift;
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_sh  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
      r_bcd_out <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_bin_sh  <= bus.bin_in;
      r_acc     <= '0;
      r_cnt     <= c_CNT_INIT;
      r_ovf_int <= 1'b0;
    end else if (r_state == S_CONV) begin
      r_bin_sh  <= w_bin_shift;
      r_acc     <= w_acc_shift;
      r_cnt     <= r_cnt - c_CNT_ONE;
      r_ovf_int <= w_ovf_step;
      if (w_last) begin
        r_bcd_out <= w_result;
        r_ovf     <= w_ovf_step;
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.bcd_out = r_bcd_out;
  assign bus.ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_dd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_dd_ctrl
//  Purpose  : Directed self-checking bench for bin2bcd_dd_ctrl. Two instances
//             (3-digit and 2-digit, both 8-bit operands) share clock/reset and
//             receive identical stimulus so that overflow behaviour is checked
//             alongside the normal results.
//  Config   : BIN2BCD_XS3_OUT_EN - expected results are Excess-3 coded when
//             defined, matching the design build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_dd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bin2bcd_dd_ctrl_if #(.BIN_W(8), .DIGITS(3)) u_if3 ();
  bin2bcd_dd_ctrl_if #(.BIN_W(8), .DIGITS(2)) u_if2 ();

  bin2bcd_dd_ctrl #(.BIN_W(8), .DIGITS(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (u_if3.slave)
  );

  bin2bcd_dd_ctrl #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  always #5 clk = ~clk;

  // Expected values are written as plain BCD; XS3 builds add 3 per digit.
  function automatic logic [11:0] enc3(input logic [11:0] b);
`ifdef BIN2BCD_XS3_OUT_EN
    return b + 12'h333;
`else
    return b;
`endif
  endfunction

  function automatic logic [7:0] enc2(input logic [7:0] b);
`ifdef BIN2BCD_XS3_OUT_EN
    return b + 8'h33;
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] v);
    u_if3.start  = s;
    u_if3.bin_in = v;
    u_if2.start  = s;
    u_if2.bin_in = v;
  endtask

  // One conversion on both instances: start pulse, scrambled operand after
  // acceptance, latency measured in cycles, results and pulse shape checked.
  task automatic run_conv(input string tag, input logic [7:0] v,
                          input logic [11:0] e3, input logic e3_ovf,
                          input logic [7:0] e2, input logic e2_ovf);
    int k;
    bit seen;
    @(negedge clk);
    drive(1'b1, v);
    @(negedge clk);
    drive(1'b0, ~v);
    check({tag, ".busy"}, u_if3.busy, 1);
    seen = 1'b0;
    k    = 1;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (u_if3.done) seen = 1'b1;
    end
    check({tag, ".latency"}, k, 9);
    check({tag, ".bcd3"},  u_if3.bcd_out, enc3(e3));
    check({tag, ".ovf3"},  u_if3.ovf, e3_ovf);
    check({tag, ".done2"}, u_if2.done, 1);
    check({tag, ".bcd2"},  u_if2.bcd_out, enc2(e2));
    check({tag, ".ovf2"},  u_if2.ovf, e2_ovf);
    @(negedge clk);
    check({tag, ".done_off"}, u_if3.done, 0);
    check({tag, ".idle"},     u_if3.busy, 0);
    check({tag, ".hold3"},    u_if3.bcd_out, enc3(e3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int last_i;
    int k;

    drive(1'b0, 8'd0);

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst.busy",  u_if3.busy, 0);
    check("rst.done",  u_if3.done, 0);
    check("rst.bcd3",  u_if3.bcd_out, 0);
    check("rst.ovf3",  u_if3.ovf, 0);
    check("rst.bcd2",  u_if2.bcd_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single conversions, including zero and overflow cases on the 2-digit part
    run_conv("c255", 8'd255, 12'h255, 1'b0, 8'h55, 1'b1);
    run_conv("c0",   8'd0,   12'h000, 1'b0, 8'h00, 1'b0);
    run_conv("c9",   8'd9,   12'h009, 1'b0, 8'h09, 1'b0);
    run_conv("c100", 8'd100, 12'h100, 1'b0, 8'h00, 1'b1);
    run_conv("c200", 8'd200, 12'h200, 1'b0, 8'h00, 1'b1);
    run_conv("c99",  8'd99,  12'h099, 1'b0, 8'h99, 1'b0);
    run_conv("c59",  8'd59,  12'h059, 1'b0, 8'h59, 1'b0);

    // start held high: one result every 10 cycles; operand change mid-CONV ignored
    @(negedge clk);
    drive(1'b1, 8'd37);
    dones  = 0;
    last_i = -1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 3) drive(1'b1, 8'd1);
      if (u_if3.done) begin
        dones++;
        check("held.bcd3", u_if3.bcd_out, enc3(12'h037));
        check("held.bcd2", u_if2.bcd_out, enc2(8'h37));
        if (last_i >= 0) check("held.period", i - last_i, 10);
        last_i = i;
        drive(1'b1, 8'd37);
      end
    end
    check("held.count", dones, 3);
    drive(1'b0, 8'd37);
    k = 0;
    while (u_if3.busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("held.drain", u_if3.busy, 0);

    // Asynchronous reset three cycles into CONV
    @(negedge clk);
    drive(1'b1, 8'd200);
    @(negedge clk);
    drive(1'b0, 8'd200);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.busy", u_if3.busy, 0);
    check("arst.done", u_if3.done, 0);
    check("arst.bcd3", u_if3.bcd_out, 0);
    check("arst.ovf3", u_if3.ovf, 0);
    check("arst.bcd2", u_if2.bcd_out, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (u_if3.done) dones++;
    end
    check("arst.nodone", dones, 0);
    run_conv("c42", 8'd42, 12'h042, 1'b0, 8'h42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
